// File: rtl/tri_queue.sv
// tri_queue: triangle/color FIFO feeding the rasterizer R10 stage; define TRI_QUEUE_CULL_EN to drop zero-area triangles
module tri_queue #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]         in_color_U,
    input  logic                                         in_valid_H,
    output logic                                         in_ready_H,
    input  logic                                         halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]         color_R10U,
    output logic                                         validTri_R10H,
    output logic        [$clog2(DEPTH):0]                count_U,
    output logic        [15:0]                           cull_count_U
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

    tri_t tri_mem [DEPTH];
    col_t col_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic accept, write, pop;

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a full queue.
    assign in_ready_H    = count_U < CW'(DEPTH);
    assign validTri_R10H = count_U != '0;
    assign accept        = in_valid_H && in_ready_H;
    assign pop           = validTri_R10H && halt_RnnnnL;
    assign tri_R10S      = validTri_R10H ? tri_mem[rd_ptr] : '0;
    assign color_R10U    = validTri_R10H ? col_mem[rd_ptr] : '0;

`ifdef TRI_QUEUE_CULL_EN
    // Full-width signed edge products; no truncation so any sign of area is exact.
    localparam int PW = 2 * (SIGFIG + 1) + 1;
    logic signed [PW-1:0] dx1, dy1, dx2, dy2, area;
    logic cull;

    assign dx1  = PW'($signed(in_tri_S[1][0])) - PW'($signed(in_tri_S[0][0]));
    assign dy1  = PW'($signed(in_tri_S[1][1])) - PW'($signed(in_tri_S[0][1]));
    assign dx2  = PW'($signed(in_tri_S[2][0])) - PW'($signed(in_tri_S[0][0]));
    assign dy2  = PW'($signed(in_tri_S[2][1])) - PW'($signed(in_tri_S[0][1]));
    assign area = dx1 * dy2 - dx2 * dy1;
    assign cull = area == '0;
    assign write = accept && !cull;

    // Saturating count of accepted-but-discarded degenerate triangles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cull_count_U <= '0;
        else if (accept && cull && cull_count_U != 16'hFFFF)
            cull_count_U <= cull_count_U + 16'd1;
    end
`else
    assign write        = accept;
    assign cull_count_U = '0;
`endif

    // Queue bookkeeping; reset discards every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_U <= '0;
        end else begin
            if (write)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_U <= count_U + CW'(write) - CW'(pop);
        end
    end

    // Payload storage; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge clk) begin
        if (write) begin
            tri_mem[wr_ptr] <= in_tri_S;
            col_mem[wr_ptr] <= in_color_U;
        end
    end
endmodule

// File: tb/tb_tri_queue.sv
// tb_tri_queue: directed self-checking bench for tri_queue (DEPTH=4)
module tb_tri_queue;
    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int DEPTH  = 4;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid_H = 1'b0;
    logic halt_RnnnnL = 1'b0;
    tri_t in_tri_S = '0;
    col_t in_color_U = '0;
    tri_t tri_R10S;
    col_t color_R10U;
    logic in_ready_H, validTri_R10H;
    logic [2:0] count_U;
    logic [15:0] cull_count_U;

    int vectors = 0;
    int miscompares = 0;
    int model[$];
    int next_id = 1;
    int pushed = 0;

    tri_queue #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_tri_S(in_tri_S),
        .in_color_U(in_color_U),
        .in_valid_H(in_valid_H),
        .in_ready_H(in_ready_H),
        .halt_RnnnnL(halt_RnnnnL),
        .tri_R10S(tri_R10S),
        .color_R10U(color_R10U),
        .validTri_R10H(validTri_R10H),
        .count_U(count_U),
        .cull_count_U(cull_count_U)
    );

    always #5 clk = ~clk;

    function automatic tri_t mk_tri(input int id);
        tri_t t = '0;
        t[0][0] = 24'(id);
        t[0][2] = 24'(id);
        t[1][0] = 24'(id + 100);
        t[1][2] = 24'(id + 1);
        t[2][0] = 24'(id);
        t[2][1] = 24'd100;
        t[2][2] = 24'(id + 2);
        return t;
    endfunction

    function automatic col_t mk_col(input int id);
        col_t c;
        c[0] = 24'(id);
        c[1] = 24'(id) ^ 24'h0ABCDE;
        c[2] = ~24'(id);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n = model.size();
        chk({tag, "_count"}, 256'(count_U), 256'(n));
        chk({tag, "_valid"}, 256'(validTri_R10H), 256'(n != 0));
        chk({tag, "_ready"}, 256'(in_ready_H), 256'(n < DEPTH));
        chk({tag, "_tri"}, 256'(tri_R10S), n != 0 ? 256'(mk_tri(model[0])) : 256'(0));
        chk({tag, "_color"}, 256'(color_R10U), n != 0 ? 256'(mk_col(model[0])) : 256'(0));
    endtask

    task automatic cyc(input logic v, input logic h);
        logic push, pop;
        in_valid_H  = v;
        halt_RnnnnL = h;
        in_tri_S    = mk_tri(next_id);
        in_color_U  = mk_col(next_id);
        push = v && model.size() < DEPTH;
        pop  = model.size() != 0 && h;
        @(posedge clk);
        #1;
        if (pop)
            void'(model.pop_front());
        if (push) begin
            model.push_back(next_id);
            next_id++;
            pushed++;
        end
        check_state("cyc");
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && model.size() != 0; i++)
            cyc(1'b0, 1'b1);
        chk("drain_empty", 256'(count_U), 256'(0));
    endtask

    initial begin
        tri_t zt, gt;
        int base;
        #12;
        chk("rst_count", 256'(count_U), 256'(0));
        chk("rst_valid", 256'(validTri_R10H), 256'(0));
        chk("rst_ready", 256'(in_ready_H), 256'(1));
        chk("rst_tri", 256'(tri_R10S), 256'(0));
        chk("rst_cull", 256'(cull_count_U), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill under halt: head stays triangle 1, fifth offer refused.
        base = next_id;
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0);
        chk("full_count", 256'(count_U), 256'(4));
        chk("full_ready", 256'(in_ready_H), 256'(0));
        chk("full_head", 256'(tri_R10S), 256'(mk_tri(base)));
        cyc(1'b1, 1'b0);
        chk("fifth_count", 256'(count_U), 256'(4));
        chk("fifth_head", 256'(tri_R10S), 256'(mk_tri(base)));

        // Full with pop: push refused this cycle, accepted next (4->3->4).
        cyc(1'b1, 1'b1);
        chk("fullpop_count", 256'(count_U), 256'(3));
        chk("fullpop_head", 256'(tri_R10S), 256'(mk_tri(base + 1)));
        cyc(1'b1, 1'b0);
        chk("refill_count", 256'(count_U), 256'(4));

        // Release halt while offering every cycle: FIFO order, one per cycle.
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b1);
        drain();

        // Latency and hold: A visible one cycle after push, stable under halt.
        base = next_id;
        cyc(1'b1, 1'b0);
        chk("lat_valid", 256'(validTri_R10H), 256'(1));
        chk("lat_head", 256'(tri_R10S), 256'(mk_tri(base)));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            chk("hold_head", 256'(tri_R10S), 256'(mk_tri(base)));
        end
        cyc(1'b0, 1'b1);
        chk("consumed_valid", 256'(validTri_R10H), 256'(0));

        // Many pointer wraps with a periodic halt pattern.
        pushed = 0;
        for (int i = 0; i < 64; i++)
            cyc(1'b1, (i % 4) != 3);
        drain();
        chk("wrap_enough", 256'(pushed >= 10 * DEPTH), 256'(1));

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0);
        in_valid_H = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 256'(count_U), 256'(0));
        chk("arst_valid", 256'(validTri_R10H), 256'(0));
        chk("arst_ready", 256'(in_ready_H), 256'(1));
        chk("arst_tri", 256'(tri_R10S), 256'(0));
        chk("arst_color", 256'(color_R10U), 256'(0));
        model.delete();
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-area and non-degenerate triangles.
        zt = '0;
        zt[1][0] = 24'd1024;
        zt[1][1] = 24'd1024;
        zt[2][0] = 24'd2048;
        zt[2][1] = 24'd2048;
        gt = '0;
        gt[1][0] = 24'd1024;
        gt[2][1] = 24'd1024;
        halt_RnnnnL = 1'b0;
        in_tri_S = zt;
        in_color_U = '0;
        in_valid_H = 1'b1;
        chk("zero_ready", 256'(in_ready_H), 256'(1));
        @(posedge clk);
        #1;
        in_tri_S = gt;
        @(posedge clk);
        #1;
        in_valid_H = 1'b0;
`ifdef TRI_QUEUE_CULL_EN
        chk("cull_count_q", 256'(count_U), 256'(1));
        chk("cull_head", 256'(tri_R10S), 256'(gt));
        chk("cull_one", 256'(cull_count_U), 256'(1));
        in_tri_S = zt;
        in_valid_H = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("cull_sat", 256'(cull_count_U), 256'(16'hFFFF));
        repeat (3) @(posedge clk);
        #1;
        in_valid_H = 1'b0;
        chk("cull_hold_sat", 256'(cull_count_U), 256'(16'hFFFF));
        chk("cull_count_after", 256'(count_U), 256'(1));
`else
        chk("nocull_count", 256'(count_U), 256'(2));
        chk("nocull_head", 256'(tri_R10S), 256'(zt));
        chk("nocull_zero", 256'(cull_count_U), 256'(0));
        halt_RnnnnL = 1'b1;
        @(posedge clk);
        #1;
        chk("nocull_second", 256'(tri_R10S), 256'(gt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tri_queue.md
# tri_queue

Triangle input queue sitting directly upstream of the rasterizer's bounding-box stage. It accepts triangles and colors from a producer over a valid/ready handshake, buffers up to DEPTH of them, and presents the oldest one on the rasterizer's R10 inputs. It holds that triangle while the rasterizer asserts halt, and optionally culls zero-area triangles before they are queued.

## Interface
- SIGFIG, 24, bits per coordinate / color channel
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x=0, y=1, z=2)
- COLORS, 3, color channels
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_tri_S  in  VERTS×AXIS×SIGFIG signed  producer triangle
- in_color_U  in  COLORS×SIGFIG unsigned  producer color
- in_valid_H  in  1  producer data valid
- in_ready_H  out  1  queue can accept
- halt_RnnnnL  in  1  rasterizer halt, active-low (0 = stall)
- tri_R10S  out  VERTS×AXIS×SIGFIG signed  head triangle
- color_R10U  out  COLORS×SIGFIG unsigned  head color
- validTri_R10H  out  1  head valid
- count_U  out  $clog2(DEPTH)+1  occupied entries
- cull_count_U  out  16  culled-triangle count; tied to 0 when culling is compiled out

## Operation
- Storage: circular register array with rd_ptr/wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count.
- Push when in_valid_H && in_ready_H. in_ready_H = (count < DEPTH). It depends only on the registered count: a pop in the same cycle does not open space while full.
- Pop when validTri_R10H && halt_RnnnnL. The rasterizer consumes the head on exactly these cycles.
- validTri_R10H = (count != 0).
- tri_R10S/color_R10U = mem[rd_ptr] when count != 0; all zeros when empty. No combinational path from in_* to any output.
- With halt_RnnnnL=0, head data and validTri_R10H stay stable; pushes continue until full.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Push into empty queue: entry visible on outputs the next cycle.
- Reset values: count 0, pointers 0, validTri_R10H 0, tri/color outputs 0, in_ready_H 1, cull_count_U 0. Memory contents need not be reset.
- Reset asserted mid-operation: all queued triangles are discarded immediately (asynchronously).

## Timing
- Latency in_valid → validTri_R10H: 1 cycle when the queue is empty and not culled.
- Throughput: one push and one pop per cycle.
- Full-rate streaming needs DEPTH ≥ 2; with halt held high, steady state is count = 1.
- All state updates occur on the rising clk edge; rst acts asynchronously.

## Configuration
- Macro: TRI_QUEUE_CULL_EN.
- Defined:
  - Compute area = (x1−x0)(y2−y0) − (x2−x0)(y1−y0) from in_tri_S, at full width 2·(SIGFIG+1)+1 signed with no truncation.
  - A handshaken triangle with area == 0 is accepted (in_ready_H obeys the normal rule) but not written. Pointers and count are unchanged.
  - cull_count_U increments and saturates at 16'hFFFF.
  - Nonzero area of either sign is queued.
- Undefined: no area logic; every handshaken triangle is queued; cull_count_U = 0.

## Test plan
- Reset mid-stream with 3 entries queued, rst pulsed → count_U=0, validTri_R10H=0, outputs 0, in_ready_H=1 in the same cycle.
- Push 4 triangles with halt_RnnnnL=0 → count_U=4, in_ready_H=0. A 5th in_valid is not accepted. Head equals triangle 1 throughout.
- Release halt while pushing every cycle with DEPTH=4 → one triangle consumed per cycle, in FIFO order, with no gaps and no duplicates.
- Full queue, halt=1, in_valid=1 → pop proceeds and the push is refused that cycle. The push is accepted the next cycle (count 4→3→4).
- Push A, then toggle halt 1/0/1 → A appears 1 cycle after push and is held stable during halt=0. Consumed count matches pushed count after 10 wrap-arounds of the pointers.
- TRI_QUEUE_CULL_EN defined, push vertices (0,0),(1024,1024),(2048,2048) → in_ready_H=1, no queue entry, cull_count_U=1. A triangle (0,0),(1024,0),(0,1024) is queued. Repeat the culled push to drive the counter to saturation at 16'hFFFF.
